spi_cmd_slave: RTL

SPI_CMD_SLAVE -- requirements
Module: spi_cmd_slave

---
 rtl/spi_cmd_pkg.sv | 32 +++
 rtl/spi_cmd_slave_if.sv | 11 +
 rtl/spi_byte_shifter.sv | 76 +++++++
 rtl/spi_cmd_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command slave: opcode masks, opcode
// classification helper and the byte-level FSM state type.
package spi_cmd_pkg;

    localparam logic [7:0] OP_WR_BASE = 8'h90;  // write opcode family 0x9a
    localparam logic [7:0] OP_RD_BASE = 8'hA0;  // read opcode family 0xAa
    localparam logic [7:0] OP_ACT_MAX = 8'h0F;  // action opcodes 0x00..0x0F
    localparam logic [7:0] OP_HI_MASK = 8'hF0;  // selects the opcode family

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_RD_DATA
    } state_e;

    typedef enum logic [1:0] {
        KIND_ACTION,
        KIND_WRITE,
        KIND_READ,
        KIND_ILLEGAL
    } op_kind_e;

    // Classifies an opcode byte by family only; the address range check is
    // left to the caller because it depends on NUM_REGS.
    function automatic op_kind_e decode_op(input logic [7:0] op);
        if (op <= OP_ACT_MAX)                return KIND_ACTION;
        if ((op & OP_HI_MASK) == OP_WR_BASE) return KIND_WRITE;
        if ((op & OP_HI_MASK) == OP_RD_BASE) return KIND_READ;
        return KIND_ILLEGAL;
    endfunction

endpackage

// File: rtl/spi_cmd_slave_if.sv
// SPI pin bundle (mode 0). The master modport is the bus driver side, the
// slave modport is used by spi_cmd_slave and its byte shifter.
interface spi_cmd_slave_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs_n, output mosi, input miso);
    modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte shifter: synchronises the pins into clk_in, detects sclk
// edges, counts bits MSB first and pulses byte_done_o once per full byte.
// The transmit byte is reloaded from tx_byte_i whenever no byte is in flight.
module spi_byte_shifter (
    input  logic           clk_in,
    input  logic           sys_rst_n,
    spi_cmd_slave_if.slave spi,
    input  logic [7:0]     tx_byte_i,
    output logic [7:0]     rx_byte_o,
    output logic           byte_done_o
);

    logic [1:0] sclk_sync_q;
    logic [1:0] cs_n_sync_q;
    logic [1:0] mosi_sync_q;
    logic       sclk_prev_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] rx_q;
    logic [7:0] tx_q;
    logic       done_q;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_active;

    // Two-flop synchronisers for the asynchronous pins plus sclk history.
    // NOTE: every clocked register uses <= so all flops sample pre-edge values.
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sclk_sync_q <= '0;
            cs_n_sync_q <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], spi.sclk};
            cs_n_sync_q <= {cs_n_sync_q[0], spi.cs_n};
            mosi_sync_q <= {mosi_sync_q[0], spi.mosi};
            sclk_prev_q <= sclk_sync_q[1];
        end
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
    assign cs_active = ~cs_n_sync_q[1];

    // Bit counter, receive shift on sclk rise, transmit shift on sclk fall.
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            done_q    <= 1'b0;
        end else if (!cs_active) begin
            // Deselect drops any partial byte silently.
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            tx_q      <= tx_byte_i;
        end else begin
            done_q <= sclk_rise && (bit_cnt_q == 3'd7);
            if (sclk_rise) begin
                rx_q      <= {rx_q[6:0], mosi_sync_q[1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (sclk_fall && (bit_cnt_q != 3'd0)) begin
                tx_q <= {tx_q[6:0], 1'b0};
            end else if (bit_cnt_q == 3'd0) begin
                tx_q <= tx_byte_i;
            end
        end
    end

    assign rx_byte_o   = rx_q;
    assign byte_done_o = done_q;
    assign spi.miso    = cs_active & tx_q[7];

endmodule

// File: rtl/spi_cmd_slave.sv
// SPI command slave: decodes action, register-write and status-read opcodes
// from a byte stream and maintains a NUM_REGS x REG_W register file.
// Optional macro SPI_CMD_TIMEOUT_EN adds an inter-byte watchdog that aborts a
// pending write/read payload after TIMEOUT_CYC idle clk_in cycles.
module spi_cmd_slave
    import spi_cmd_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int REG_W       = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                      clk_in,
    input  logic                      sys_rst_n,
    spi_cmd_slave_if.slave            spi,
    input  logic [NUM_REGS*REG_W-1:0] status_in,
    output logic [NUM_REGS*REG_W-1:0] reg_q,
    output logic                      wr_strobe,
    output logic [3:0]                wr_addr,
    output logic                      cmd_strobe,
    output logic [3:0]                cmd_code,
    output logic                      frame_err
);

    localparam int NBYTES = REG_W / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [7:0]       rx_byte;
    logic [7:0]       tx_byte;
    logic             byte_done;
    logic             timeout_hit;

    state_e           state_q, state_d;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [3:0]       addr_q, addr_d;
    logic [REG_W-1:0] data_q, data_d;
    logic [REG_W-1:0] snap_q, snap_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic [3:0]       wr_addr_q, wr_addr_d;
    logic             cmd_strobe_q, cmd_strobe_d;
    logic [3:0]       cmd_code_q, cmd_code_d;
    logic             frame_err_q, frame_err_d;
    logic             commit;

    logic             addr_ok;
    logic [REG_W-1:0] status_sel;
    logic [REG_W-1:0] reg_file_q [NUM_REGS];

    spi_byte_shifter u_shifter (
        .clk_in      (clk_in),
        .sys_rst_n   (sys_rst_n),
        .spi         (spi),
        .tx_byte_i   (tx_byte),
        .rx_byte_o   (rx_byte),
        .byte_done_o (byte_done)
    );

    // During a read payload the low byte of the snapshot is the next byte out.
    assign tx_byte = (state_q == ST_RD_DATA) ? snap_q[7:0] : 8'h00;

    // Address range check and status channel mux for the opcode low nibble.
    always_comb begin
        addr_ok    = int'(rx_byte[3:0]) < NUM_REGS;
        status_sel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rx_byte[3:0] == 4'(k)) status_sel = status_in[k*REG_W +: REG_W];
        end
    end

`ifdef SPI_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    // Watchdog: counts idle cycles while a payload is pending.
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_cnt_q <= '0;
        end else if ((state_q == ST_IDLE) || byte_done) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    // A byte finishing in the same cycle takes priority over the abort.
    assign timeout_hit = (state_q != ST_IDLE) && !byte_done &&
                         (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`else
    // Watchdog compiled out: this constant is always false, so a partial
    // command waits for its remaining bytes indefinitely.
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    // Byte-level command FSM: next state, payload assembly and strobes.
    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        snap_d       = snap_q;
        wr_strobe_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        cmd_strobe_d = 1'b0;
        cmd_code_d   = cmd_code_q;
        frame_err_d  = 1'b0;
        commit       = 1'b0;

        if (timeout_hit) begin
            state_d     = ST_IDLE;
            byte_cnt_d  = '0;
            frame_err_d = 1'b1;
        end else if (byte_done) begin
            case (state_q)
                ST_IDLE: begin
                    byte_cnt_d = '0;
                    case (decode_op(rx_byte))
                        KIND_ACTION: begin
                            cmd_strobe_d = 1'b1;
                            cmd_code_d   = rx_byte[3:0];
                        end
                        KIND_WRITE: begin
                            if (addr_ok) begin
                                state_d = ST_WR_DATA;
                                addr_d  = rx_byte[3:0];
                                data_d  = '0;
                            end else begin
                                frame_err_d = 1'b1;
                            end
                        end
                        KIND_READ: begin
                            if (addr_ok) begin
                                state_d = ST_RD_DATA;
                                snap_d  = status_sel;
                            end else begin
                                frame_err_d = 1'b1;
                            end
                        end
                        default: frame_err_d = 1'b1;
                    endcase
                end
                ST_WR_DATA: begin
                    // Bytes arrive LSB first: shift down, insert at the top.
                    data_d = (data_q >> 8) | (REG_W'(rx_byte) << (REG_W - 8));
                    if (byte_cnt_q == BCW'(NBYTES - 1)) begin
                        state_d     = ST_IDLE;
                        commit      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = addr_q;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
                ST_RD_DATA: begin
                    snap_d = snap_q >> 8;
                    if (byte_cnt_q == BCW'(NBYTES - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state, payload context and registered outputs.
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            snap_q       <= '0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            cmd_strobe_q <= 1'b0;
            cmd_code_q   <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            snap_q       <= snap_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            cmd_strobe_q <= cmd_strobe_d;
            cmd_code_q   <= cmd_code_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Register file, written only on a completed write payload.
    // NOTE: this storage is flops that must read 0 after reset, so it is reset.
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) reg_file_q[k] <= '0;
        end else if (commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (addr_q == 4'(k)) reg_file_q[k] <= data_d;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign reg_q[g*REG_W +: REG_W] = reg_file_q[g];
    end

    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign cmd_strobe = cmd_strobe_q;
    assign cmd_code   = cmd_code_q;
    assign frame_err  = frame_err_q;

endmodule
